// File: rtl/lfsr_number_gen.sv
// Bounded pseudo-random number generator driven by a Galois LFSR.
// A req triggers repeated draws until one fits max_val (and differs from the last).
`timescale 1ns/1ps
module lfsr_number_gen #(
  parameter int                WIDTH     = 4,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                NO_REPEAT = 1,
  parameter int                MAX_TRIES = 8,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              req,
  output logic [WIDTH-1:0]  result,
  output logic              valid,
  output logic              busy
);

  localparam int TW = (MAX_TRIES > 2) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t            state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [TW-1:0]     tries_q;
  logic [WIDTH-1:0]  result_q;
  logic              valid_q;
  logic              busy_q;

  logic [WIDTH-1:0]  cand;
  logic              fits;
  logic              fresh;
  logic [WIDTH:0]    bump;
  logic [WIDTH-1:0]  fallback;

  // A zero seed would lock the LFSR, so it is replaced by SEED.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed == '0) ? SEED : seed;
    end else if (enable) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_comb begin
    cand     = lfsr_q[WIDTH-1:0];
    fits     = (cand <= max_val);
    fresh    = (NO_REPEAT == 0) || (cand != result_q);
    bump     = {1'b0, result_q} + 1'b1;
    fallback = (bump > {1'b0, max_val}) ? '0 : bump[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      tries_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b0;
      if (enable) begin
        unique case (state_q)
          IDLE: begin
            if (req) begin
              state_q <= DRAW;
              busy_q  <= 1'b1;
              tries_q <= '0;
            end
          end
          DRAW: begin
            if (max_val == '0) begin
              result_q <= '0;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else if (fits && fresh) begin
              result_q <= cand;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else if (tries_q == LAST_TRY) begin
              result_q <= fallback;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              tries_q <= tries_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_lfsr_number_gen.sv
// Scoreboard bench for lfsr_number_gen: stimulus pushes predicted draws,
// a negedge monitor pops and compares on every valid pulse.
`timescale 1ns/1ps
module tb_lfsr_number_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        seed_load;
  logic [15:0] seed;
  logic [3:0]  max_val;
  logic        req;
  logic [3:0]  result;
  logic        valid;
  logic        busy;

  always #5 clk = ~clk;

  lfsr_number_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .seed_load (seed_load),
    .seed      (seed),
    .max_val   (max_val),
    .req       (req),
    .result    (result),
    .valid     (valid),
    .busy      (busy)
  );

  typedef struct {
    int         due;
    int         start;
    logic [3:0] res;
  } exp_t;

  exp_t       q[$];
  logic [3:0] seen[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  prev;
  exp_t        me;
  int          lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic predict(input logic [15:0] l0, input logic [3:0] pv,
                         input logic [3:0] mv, output logic [3:0] r,
                         output int n);
    logic [15:0] l;
    l = l0;
    for (int t = 1; t <= 8; t++) begin
      if (mv == 4'd0) begin
        r = 4'd0; n = t; return;
      end
      if (l[3:0] <= mv && l[3:0] != pv) begin
        r = l[3:0]; n = t; return;
      end
      l = step(l);
    end
    r = (pv >= mv) ? 4'd0 : pv + 4'd1;
    n = 8;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_lfsr = 16'hACE1;
    else if (seed_load) m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    else if (enable) m_lfsr = step(m_lfsr);
    #1;
  endtask

  task automatic do_req(input logic [3:0] mv, input int freeze,
                        input logic hold);
    logic [3:0] r;
    int n;
    int k0;
    exp_t e;
    max_val = mv;
    req = 1'b1;
    tick();
    k0 = cyc;
    req = hold;
    if (freeze > 0) begin
      enable = 1'b0;
      repeat (freeze) begin
        tick();
        chk("frozen_busy", busy, 1);
        chk("frozen_valid", valid, 0);
      end
      enable = 1'b1;
    end
    predict(m_lfsr, prev, mv, r, n);
    e.due = k0 + freeze + n;
    e.start = k0 + freeze;
    e.res = r;
    q.push_back(e);
    prev = r;
    for (int i = 1; i <= n; i++) begin
      tick();
      req = 1'b0;
      chk((i == n) ? "done_busy" : "draw_busy", busy, (i == n) ? 0 : 1);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 result=%0h expected no pulse (cycle %0d)",
                 result, cyc);
      end else begin
        me = q.pop_front();
        chk("draw_result", result, me.res);
        chk("valid_cycle", cyc, me.due);
        lat = cyc - me.start + 1;
        chk("latency_range", (lat >= 2 && lat <= 9), 1);
        seen.push_back(result);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] ref_seq [6];
    int b0, b1, b, bad_rep, bad_rng;
    bit hit [6];
    ref_seq = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
    rst_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed = 16'h0;
    req = 1'b0; max_val = 4'd0;
    m_lfsr = 16'hACE1; prev = 4'd0;
    repeat (3) tick();
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);

    enable = 1'b1;
    rst_n = 1'b1;
    chk("lfsr_release", dut.lfsr_q, 16'hACE1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lfsr_seq", dut.lfsr_q, ref_seq[i]);
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid, 0);
      chk("idle_result", result, 0);
    end

    do_req(4'd0, 0, 1'b0);
    do_req(4'd0, 0, 1'b0);

    seed = 16'h0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("seed_zero", dut.lfsr_q, 16'hACE1);

    b0 = 0; b1 = 0;
    for (int run = 0; run < 2; run++) begin
      seed = 16'h0001; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      chk("seed_one", dut.lfsr_q, 16'h0001);
      do_req(4'd0, 0, 1'b0);
      tick();
      if (run == 0) b0 = seen.size(); else b1 = seen.size();
      repeat (10) do_req(4'd5, 0, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++)
      chk("seed_stream", seen[b1 + i], seen[b0 + i]);

    b = seen.size();
    repeat (1000) do_req(4'd5, 0, 1'b0);
    tick();
    chk("bulk_count", seen.size() - b, 1000);
    bad_rep = 0; bad_rng = 0;
    for (int i = b; i < seen.size(); i++) begin
      if (seen[i] > 4'd5) bad_rng++;
      else hit[seen[i]] = 1'b1;
      if (i > b && seen[i] == seen[i-1]) bad_rep++;
    end
    chk("bulk_range", bad_rng, 0);
    chk("bulk_norepeat", bad_rep, 0);
    for (int v = 0; v < 6; v++) chk("bulk_cover", hit[v], 1);

    do_req(4'd5, 0, 1'b1);
    repeat (4) tick();
    do_req(4'd5, 3, 1'b1);
    repeat (4) tick();

    for (int i = 0; i < 10 && prev == 4'd0; i++) do_req(4'd5, 0, 1'b0);
    max_val = 4'd5;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    m_lfsr = 16'hACE1;
    prev = 4'd0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_valid", valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    do_req(4'd0, 0, 1'b0);
    do_req(4'd3, 0, 1'b0);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
